writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  MEM/WB pipeline register plus writeback stage of the 5-stage MIPS core. Captures the memory-stage
//  outputs each cycle, selects the register-file write result, and retires syscalls through a
//  console handshake FSM. Asserts sys_stall to the hazard unit while a syscall is in progress.
//  Latches halted on exit (v0=10).
// PARAMETERS
//  DATA_W      32  datapath width
//  REG_W        5  register address width
//  SYS_PINT     1  v0 code: print integer (a0)
//  SYS_EXIT    10  v0 code: halt
//  SYS_PCHAR   11  v0 code: print character (a0[7:0])
// PORTS
//  clk          in   1       core clock, rising edge
//  rst_n        in   1       synchronous reset, active-low
//  stall_w      in   1       hazard unit: hold W register
//  flush_w      in   1       hazard unit: load bubble into W register
//  RegWriteM    in   1       control: instruction writes a register
//  MemtoRegM    in   1       control: result comes from data memory
//  syscallM     in   1       control: instruction is a syscall
//  RD           in   DATA_W  data memory read data
//  ALUOutM      in   DATA_W  ALU result
//  WriteRegM    in   REG_W   destination register
//  v0M, a0M     in   DATA_W  $v0/$a0 values travelling with the syscall
//  cons_ready   in   1       console accepts cons_data this cycle
//  RegWriteW    out  1       register-file write enable
//  WriteRegW    out  REG_W   register-file write address (also to hazard unit)
//  ResultW      out  DATA_W  register-file write data (also forwarded)
//  sys_stall    out  1       freeze F/D/E/M stages and W register
//  cons_valid   out  1       console data valid
//  cons_data    out  DATA_W  integer, or char zero-extended from a0[7:0]
//  cons_is_char out  1       1 = character, 0 = integer
//  halted       out  1       exit syscall retired; sticky until reset
// BEHAVIOUR
//  - Reset: W register, all outputs and sys_done = 0; FSM = IDLE.
//  - W register update priority at each rising edge:
//    rst_n=0 > halted (hold) > sys_stall (hold) > stall_w (hold) > flush_w (bubble: all fields 0) > load M.
//  - A bubble has syscallW=0 and RegWriteW=0, so it retires nothing.
//  - Latency: M inputs appear on W outputs 1 cycle later.
//  - ResultW = MemtoRegW ? RDW : ALUOutW (combinational from the W register).
//  - RegWriteW = RegWriteW_reg & ~halted.
//  - sys_done: set on a console handshake; cleared whenever the W register loads new contents.
//    A syscall is retired at most once even if stall_w holds it.
//  - FSM states IDLE, EMIT, HALT:
//    IDLE: syscallW & ~sys_done & (v0W==SYS_PINT | v0W==SYS_PCHAR) -> EMIT; sys_stall=1 this cycle.
//          syscallW & v0W==SYS_EXIT -> HALT.
//          Any other v0 -> no action, no stall (treated as nop).
//    EMIT: cons_valid=1. cons_data and cons_is_char come from the W register and stay stable until accepted.
//          cons_ready=1 -> handshake: set sys_done, go to IDLE, sys_stall=0 this cycle (W may advance at this edge).
//          cons_ready=0 -> stay, sys_stall=1.
//    HALT: halted=1, sys_stall=1, cons_valid=0. Leave only by reset.
//  - Minimum print retire time: 2 cycles in W (IDLE detect + EMIT with cons_ready=1).
//  - cons_valid must never drop before cons_ready; cons_data must not change while cons_valid=1.
//  - flush_w or stall_w during EMIT: ignored; sys_stall takes precedence.
//  - Reset mid-EMIT: cons_valid=0 after the reset edge; no partial output.
//  - Syscall whose RegWriteM=1: the register write is still performed (write enable is not gated by syscall).
// TESTING
//  1. ALU op RegWriteM=1, MemtoRegM=0, ALUOutM=0x1234, WriteRegM=8 -> next cycle RegWriteW=1, WriteRegW=8,
//     ResultW=0x1234.
//  2. Load MemtoRegM=1, RD=0xDEADBEEF, ALUOutM=0x40 -> ResultW=0xDEADBEEF.
//     Then flush_w=1 -> RegWriteW=0, ResultW=0.
//  3. Syscall v0=1, a0=42, cons_ready held 0 for 3 cycles then 1 -> sys_stall=1 for 4 cycles,
//     cons_valid=1 with cons_data=42 and cons_is_char=0 throughout, exactly one handshake, W then advances.
//  4. Syscall v0=11, a0=0x1FF41, stall_w=1 held 5 cycles, cons_ready=1 -> cons_data=0x41, cons_is_char=1,
//     exactly one cons_valid&cons_ready.
//  5. Syscall v0=10 -> next cycle halted=1, sys_stall=1, RegWriteW=0 forever.
//     rst_n=0 for 1 cycle -> all outputs 0, FSM IDLE.
//  6. rst_n=0 during EMIT (cons_ready=0) -> cons_valid=0, sys_stall=0 after the edge.
//     Syscall v0=5 -> no stall, no console traffic.

Source files
------------

// File: rtl/writeback_if.sv
// MEM/WB boundary bundle: memory-stage inputs, register-file writeback, hazard and console handshake.
// The slave modport is the writeback stage; the master modport is its surrounding pipeline/console.
interface writeback_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) ();
    logic              stall_w;
    logic              flush_w;
    logic              RegWriteM;
    logic              MemtoRegM;
    logic              syscallM;
    logic [DATA_W-1:0] RD;
    logic [DATA_W-1:0] ALUOutM;
    logic [REG_W-1:0]  WriteRegM;
    logic [DATA_W-1:0] v0M;
    logic [DATA_W-1:0] a0M;
    logic              cons_ready;

    logic              RegWriteW;
    logic [REG_W-1:0]  WriteRegW;
    logic [DATA_W-1:0] ResultW;
    logic              sys_stall;
    logic              cons_valid;
    logic [DATA_W-1:0] cons_data;
    logic              cons_is_char;
    logic              halted;

    modport slave (
        input  stall_w, flush_w, RegWriteM, MemtoRegM, syscallM, RD, ALUOutM,
               WriteRegM, v0M, a0M, cons_ready,
        output RegWriteW, WriteRegW, ResultW, sys_stall, cons_valid, cons_data,
               cons_is_char, halted
    );

    modport master (
        output stall_w, flush_w, RegWriteM, MemtoRegM, syscallM, RD, ALUOutM,
               WriteRegM, v0M, a0M, cons_ready,
        input  RegWriteW, WriteRegW, ResultW, sys_stall, cons_valid, cons_data,
               cons_is_char, halted
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback stage; retires print/exit syscalls through a
// console handshake and freezes the pipeline while a syscall is in progress.
module writeback_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned SYS_PINT  = 1,
    parameter int unsigned SYS_EXIT  = 10,
    parameter int unsigned SYS_PCHAR = 11
) (
    input  logic     clk,
    input  logic     rst_n,
    writeback_if.slave wb
);
    typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_HALT} state_e;

    state_e            state_q, state_d;
    logic              reg_write_q, mem_to_reg_q, syscall_q, sys_done_q, sys_done_d;
    logic [DATA_W-1:0] rd_q, alu_out_q, v0_q, a0_q;
    logic [REG_W-1:0]  write_reg_q;

    logic is_pint, is_pchar, is_exit, is_print;
    logic sys_stall, cons_valid, halted, handshake, w_load;

    assign is_pint  = (v0_q == DATA_W'(SYS_PINT));
    assign is_pchar = (v0_q == DATA_W'(SYS_PCHAR));
    assign is_exit  = (v0_q == DATA_W'(SYS_EXIT));
    assign is_print = is_pint | is_pchar;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (syscall_q && is_exit)                      state_d = ST_HALT;
                else if (syscall_q && !sys_done_q && is_print) state_d = ST_EMIT;
            end
            ST_EMIT: if (wb.cons_ready) state_d = ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; the exit syscall also freezes the pipeline in its detect cycle
    always_comb begin
        sys_stall  = 1'b0;
        cons_valid = 1'b0;
        halted     = 1'b0;
        handshake  = 1'b0;
        case (state_q)
            ST_IDLE: sys_stall = syscall_q && (is_exit || (!sys_done_q && is_print));
            ST_EMIT: begin
                cons_valid = 1'b1;
                handshake  = wb.cons_ready;
                sys_stall  = !wb.cons_ready;
            end
            ST_HALT: begin
                halted    = 1'b1;
                sys_stall = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_load = !halted && !sys_stall && !wb.stall_w;

    // A retired syscall stays retired until different contents enter W
    always_comb begin
        sys_done_d = sys_done_q;
        if (w_load)         sys_done_d = 1'b0;
        else if (handshake) sys_done_d = 1'b1;
    end

    // W pipeline register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            syscall_q    <= 1'b0;
            rd_q         <= '0;
            alu_out_q    <= '0;
            write_reg_q  <= '0;
            v0_q         <= '0;
            a0_q         <= '0;
            sys_done_q   <= 1'b0;
        end else begin
            sys_done_q <= sys_done_d;
            if (w_load) begin
                if (wb.flush_w) begin
                    reg_write_q  <= 1'b0;
                    mem_to_reg_q <= 1'b0;
                    syscall_q    <= 1'b0;
                    rd_q         <= '0;
                    alu_out_q    <= '0;
                    write_reg_q  <= '0;
                    v0_q         <= '0;
                    a0_q         <= '0;
                end else begin
                    reg_write_q  <= wb.RegWriteM;
                    mem_to_reg_q <= wb.MemtoRegM;
                    syscall_q    <= wb.syscallM;
                    rd_q         <= wb.RD;
                    alu_out_q    <= wb.ALUOutM;
                    write_reg_q  <= wb.WriteRegM;
                    v0_q         <= wb.v0M;
                    a0_q         <= wb.a0M;
                end
            end
        end
    end

    assign wb.RegWriteW    = reg_write_q & ~halted;
    assign wb.WriteRegW    = write_reg_q;
    assign wb.ResultW      = mem_to_reg_q ? rd_q : alu_out_q;
    assign wb.sys_stall    = sys_stall;
    assign wb.cons_valid   = cons_valid;
    assign wb.cons_is_char = cons_valid & is_pchar;
    assign wb.cons_data    = !cons_valid ? '0 : (is_pchar ? DATA_W'(a0_q[7:0]) : a0_q);
    assign wb.halted       = halted;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed syscall/pipeline scenarios followed by random traffic,
// every output compared each cycle against a behavioural reference model.
module tb_writeback_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    writeback_if #(.DATA_W(32), .REG_W(5)) wb ();

    writeback_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        sys;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [31:0] v0;
        logic [31:0] a0;
    } wslot_t;

    wslot_t m_w;
    logic   m_emit, m_halt, m_done;
    int     n_checks = 0;
    int     n_errors = 0;
    int     hs_cnt, stall_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_is_print();
        return m_w.sys && (m_w.v0 == 32'd1 || m_w.v0 == 32'd11);
    endfunction

    // Pipeline freezes while halted, while a print waits for the console, or when a syscall is first seen
    function automatic logic m_stall(input logic rdy);
        if (m_halt) return 1'b1;
        if (m_emit) return !rdy;
        return (m_is_print() && !m_done) || (m_w.sys && m_w.v0 == 32'd10);
    endfunction

    task automatic model_step();
        logic rdy, stall, hs, load, nxt_emit, nxt_halt;
        if (!rst_n) begin
            m_w = '0; m_emit = 1'b0; m_halt = 1'b0; m_done = 1'b0;
            return;
        end
        rdy      = wb.cons_ready;
        stall    = m_stall(rdy);
        hs       = m_emit && rdy;
        load     = !stall && !wb.stall_w;
        nxt_emit = m_emit ? !rdy : (!m_halt && m_is_print() && !m_done);
        nxt_halt = m_halt || (!m_emit && m_w.sys && m_w.v0 == 32'd10);
        if (load)    m_done = 1'b0;
        else if (hs) m_done = 1'b1;
        if (load) begin
            if (wb.flush_w) m_w = '0;
            else m_w = '{wb.RegWriteM, wb.MemtoRegM, wb.syscallM, wb.RD, wb.ALUOutM,
                         wb.WriteRegM, wb.v0M, wb.a0M};
        end
        m_emit = nxt_emit;
        m_halt = nxt_halt;
    endtask

    task automatic check_outputs();
        logic        rdy;
        logic [31:0] exp_data;
        rdy      = wb.cons_ready;
        exp_data = !m_emit ? 32'd0 : (m_w.v0 == 32'd11 ? (m_w.a0 & 32'hFF) : m_w.a0);
        check("RegWriteW",    32'(wb.RegWriteW),    32'(m_w.rw && !m_halt));
        check("WriteRegW",    32'(wb.WriteRegW),    32'(m_w.wr));
        check("ResultW",      wb.ResultW,           m_w.m2r ? m_w.rd : m_w.alu);
        check("sys_stall",    32'(wb.sys_stall),    32'(m_stall(rdy)));
        check("cons_valid",   32'(wb.cons_valid),   32'(m_emit));
        check("cons_data",    wb.cons_data,         exp_data);
        check("cons_is_char", 32'(wb.cons_is_char), 32'(m_emit && m_w.v0 == 32'd11));
        check("halted",       32'(wb.halted),       32'(m_halt));
        if (wb.cons_valid && wb.cons_ready) hs_cnt++;
        if (wb.sys_stall) stall_cnt++;
    endtask

    // One cycle: compare at the falling edge, advance the model with the rising edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic set_m(input logic rw, input logic m2r, input logic sys, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] wr, input logic [31:0] v0,
                         input logic [31:0] a0);
        wb.RegWriteM = rw;  wb.MemtoRegM = m2r; wb.syscallM = sys; wb.RD = rd;
        wb.ALUOutM   = alu; wb.WriteRegM = wr;  wb.v0M      = v0;  wb.a0M = a0;
    endtask

    task automatic set_nop();
        set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic set_random_m();
        logic [31:0] codes [4];
        codes = '{32'd1, 32'd11, 32'd5, 32'd0};
        set_m(1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), $urandom, $urandom,
              5'($urandom), codes[$urandom_range(0, 3)], $urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        wb.stall_w = 1'b0; wb.flush_w = 1'b0; wb.cons_ready = 1'b0;
        set_nop();
        repeat (2) @(posedge clk);
        model_step();
        #1;
        rst_n = 1'b1;
        tick();

        // ALU result writeback
        set_m(1'b1, 1'b0, 1'b0, 32'h0, 32'h1234, 5'd8, 32'd0, 32'd0);
        tick();
        set_nop();
        check("alu_result", wb.ResultW, 32'h1234);
        tick();

        // Load result, then a flushed bubble
        set_m(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h40, 5'd9, 32'd0, 32'd0);
        tick();
        wb.flush_w = 1'b1;
        check("load_result", wb.ResultW, 32'hDEADBEEF);
        tick();
        wb.flush_w = 1'b0;
        check("flush_regwrite", 32'(wb.RegWriteW), 32'd0);
        tick();

        // Print integer with a slow console
        set_m(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'd1, 32'd42);
        tick();
        set_m(1'b1, 1'b0, 1'b0, 32'd0, 32'h77, 5'd3, 32'd0, 32'd0);
        hs_cnt = 0; stall_cnt = 0;
        tick(4);
        wb.cons_ready = 1'b1;
        tick();
        check("pint_stall_cycles", 32'(stall_cnt), 32'd4);
        check("pint_handshakes",   32'(hs_cnt),    32'd1);
        check("pint_advance",      wb.ResultW,     32'h77);
        tick();

        // Print character while the hazard unit holds W
        set_m(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'd11, 32'h1FF41);
        tick();
        set_nop();
        wb.stall_w = 1'b1; hs_cnt = 0;
        tick(5);
        wb.stall_w = 1'b0;
        tick(2);
        check("pchar_handshakes", 32'(hs_cnt), 32'd1);

        // Exit, then reset out of HALT
        set_m(1'b1, 1'b0, 1'b1, 32'd0, 32'd5, 5'd2, 32'd10, 32'd0);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            set_random_m();
            tick();
        end
        check("halt_sticky", 32'(wb.halted), 32'd1);
        set_nop();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during EMIT, then an unsupported syscall code
        wb.cons_ready = 1'b0;
        set_m(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0, 32'd1, 32'd7);
        tick();
        set_nop();
        tick(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("reset_emit_valid", 32'(wb.cons_valid), 32'd0);
        set_m(1'b1, 1'b0, 1'b1, 32'd0, 32'd9, 5'd4, 32'd5, 32'd3);
        hs_cnt = 0; stall_cnt = 0; wb.cons_ready = 1'b1;
        tick();
        set_nop();
        tick(3);
        check("nop_sys_stalls", 32'(stall_cnt), 32'd0);
        check("nop_sys_console", 32'(hs_cnt), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            set_random_m();
            wb.stall_w    = ($urandom_range(0, 7) == 0);
            wb.flush_w    = ($urandom_range(0, 9) == 0);
            wb.cons_ready = 1'($urandom);
            rst_n         = ($urandom_range(0, 63) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
